// File: rtl/uart_rx_line_assembler_if.sv
// Handshake bundle between the UART byte receiver, the line assembler
// and the string consumer.
interface uart_rx_line_assembler_if #(
  parameter int MAX_LEN = 128
);
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic                 rx_err;
  logic [MAX_LEN*8-1:0] line_data;
  logic [7:0]           line_length;
  logic                 line_done;
  logic                 line_busy;
  logic                 line_trunc;
  logic                 line_timeout;
  logic                 line_ack;
  logic                 drop_flag;

  modport master (
    output rx_byte, rx_valid, rx_err, line_ack,
    input  line_data, line_length, line_done,
    input  line_busy, line_trunc, line_timeout, drop_flag
  );

  modport slave (
    input  rx_byte, rx_valid, rx_err, line_ack,
    output line_data, line_length, line_done,
    output line_busy, line_trunc, line_timeout, drop_flag
  );
endinterface

// File: rtl/uart_rx_line_assembler.sv
// Packs UART bytes into a line buffer; closes on LF, idle timeout or full
// buffer, then holds the line until the consumer acknowledges it.
module uart_rx_line_assembler #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int MAX_LEN    = 128,
  parameter int IDLE_BYTES = 3
) (
  input logic sys_clk,
  input logic sys_rst,
  uart_rx_line_assembler_if.slave lif
);
  localparam longint TL = longint'(IDLE_BYTES) * 64'sd10
                        * longint'(CLK_FREQ) / longint'(BAUD_RATE);
  localparam int T  = int'(TL);
  localparam int TW = (T < 1) ? 1 : $clog2(T + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DISC = 2'd3;

  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] LF   = 8'h0A;
  localparam logic [7:0] FULL = 8'(MAX_LEN);

  logic [1:0]           state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [MAX_LEN*8-1:0] data_q;
  logic [7:0]           olen_q, olen_d;
  logic                 done_q, done_d;
  logic                 trunc_q, trunc_d;
  logic                 tmo_q, tmo_d;
  logic                 drop_q, drop_d;
  logic                 pend_q, pend_d;
  logic                 we;

  logic v, is_lf, is_cr, is_dat, tmo_hit;

  // An errored strobe never carries a usable byte.
  assign v       = lif.rx_valid && !lif.rx_err;
  assign is_lf   = v && (lif.rx_byte == LF);
  assign is_cr   = v && (lif.rx_byte == CR);
  assign is_dat  = v && !is_lf && !is_cr;
  assign tmo_hit = (cnt_q == TW'(T));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    olen_d  = olen_q;
    done_d  = 1'b0;
    trunc_d = trunc_q;
    tmo_d   = tmo_q;
    drop_d  = drop_q;
    pend_d  = pend_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_dat) begin
          we    = 1'b1;
          len_d = 8'd1;
          if (FULL == 8'd1) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            olen_d  = 8'd1;
            trunc_d = 1'b1;
            pend_d  = 1'b1;
          end else begin
            state_d = S_COLL;
          end
        end
      end
      S_COLL: begin
        if (lif.rx_err) begin
          state_d = S_IDLE;
          len_d   = '0;
          cnt_d   = '0;
        end else if (is_lf) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          olen_d  = len_q;
          cnt_d   = '0;
        end else if (is_dat) begin
          we    = 1'b1;
          len_d = len_q + 8'd1;
          cnt_d = '0;
          if (len_d == FULL) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            olen_d  = len_d;
            trunc_d = 1'b1;
            pend_d  = 1'b1;
          end
        end else if (is_cr) begin
          cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          olen_d  = len_q;
          tmo_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (v) begin
          if (!pend_q)     drop_d = 1'b1;
          else if (is_lf)  pend_d = 1'b0;
        end
        if (lif.line_ack) begin
          state_d = pend_d ? S_DISC : S_IDLE;
          pend_d  = 1'b0;
          len_d   = '0;
          olen_d  = '0;
          trunc_d = 1'b0;
          tmo_d   = 1'b0;
          drop_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_DISC: begin
        if (lif.rx_err || is_lf) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (v) begin
          cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      olen_q  <= '0;
      done_q  <= 1'b0;
      trunc_q <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      olen_q  <= olen_d;
      done_q  <= done_d;
      trunc_q <= trunc_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      for (int k = 0; k < MAX_LEN; k++) begin
        if (we && (len_q == 8'(k))) data_q[k*8 +: 8] <= lif.rx_byte;
      end
    end
  end

  assign lif.line_data    = data_q;
  assign lif.line_length  = olen_q;
  assign lif.line_done    = done_q;
  assign lif.line_busy    = (state_q == S_COLL) || (state_q == S_DISC);
  assign lif.line_trunc   = trunc_q;
  assign lif.line_timeout = tmo_q;
  assign lif.drop_flag    = drop_q;
endmodule

// File: tb/tb_uart_rx_line_assembler.sv
// Directed bench for the UART line assembler with a 4-byte buffer and
// the default 13020-clock idle timeout.
module tb_uart_rx_line_assembler;
  localparam int ML = 4;
  localparam int T  = 13020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  uart_rx_line_assembler_if #(.MAX_LEN(ML)) lif ();

  uart_rx_line_assembler #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (115_200),
    .MAX_LEN    (ML),
    .IDLE_BYTES (3)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .lif     (lif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (lif.line_done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    lif.rx_byte  = b;
    lif.rx_valid = 1'b1;
    @(negedge clk);
    lif.rx_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    lif.line_ack = 1'b1;
    @(negedge clk);
    lif.line_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".data"},  64'(lif.line_data), 64'h0);
    chk({tag, ".len"},   64'(lif.line_length), 64'h0);
    chk({tag, ".done"},  64'(lif.line_done), 64'h0);
    chk({tag, ".busy"},  64'(lif.line_busy), 64'h0);
    chk({tag, ".trunc"}, 64'(lif.line_trunc), 64'h0);
    chk({tag, ".tmo"},   64'(lif.line_timeout), 64'h0);
    chk({tag, ".drop"},  64'(lif.drop_flag), 64'h0);
  endtask

  initial begin
    int d0;
    int k;
    lif.rx_byte  = 8'h00;
    lif.rx_valid = 1'b0;
    lif.rx_err   = 1'b0;
    lif.line_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    // "AB\r\n"
    d0 = done_cnt;
    send(8'h41);
    chk("ab.busy", 64'(lif.line_busy), 64'h1);
    send(8'h42);
    send(8'h0D);
    send(8'h0A);
    chk("ab.done", 64'(lif.line_done), 64'h1);
    chk("ab.busy0", 64'(lif.line_busy), 64'h0);
    chk("ab.len", 64'(lif.line_length), 64'h2);
    chk("ab.data", 64'(lif.line_data[15:0]), 64'h4241);
    chk("ab.trunc", 64'(lif.line_trunc), 64'h0);
    chk("ab.tmo", 64'(lif.line_timeout), 64'h0);
    @(negedge clk);
    chk("ab.pulse", 64'(lif.line_done), 64'h0);
    chk("ab.ndone", 64'(done_cnt - d0), 64'h1);
    ack();
    chk("ab.ackl", 64'(lif.line_length), 64'h0);

    // empty lines then "X\n"
    d0 = done_cnt;
    send(8'h0D); send(8'h0A); send(8'h0D); send(8'h0A);
    chk("emp.busy", 64'(lif.line_busy), 64'h0);
    send(8'h58); send(8'h0A);
    @(negedge clk);
    chk("emp.ndone", 64'(done_cnt - d0), 64'h1);
    chk("emp.len", 64'(lif.line_length), 64'h1);
    chk("emp.data", 64'(lif.line_data[7:0]), 64'h58);
    ack();

    // "HI" then idle
    send(8'h48);
    send(8'h49);
    k = 0;
    while (!lif.line_done && k < T + 100) begin
      @(negedge clk);
      k++;
    end
    chk("tmo.lat", 64'(k), 64'(T + 1));
    chk("tmo.flag", 64'(lif.line_timeout), 64'h1);
    chk("tmo.len", 64'(lif.line_length), 64'h2);
    chk("tmo.data", 64'(lif.line_data[15:0]), 64'h4948);
    chk("tmo.trunc", 64'(lif.line_trunc), 64'h0);
    ack();
    chk("tmo.ack", 64'(lif.line_timeout), 64'h0);

    // truncation, ack before the tail arrives
    send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    chk("tr.done", 64'(lif.line_done), 64'h1);
    chk("tr.len", 64'(lif.line_length), 64'h4);
    chk("tr.trunc", 64'(lif.line_trunc), 64'h1);
    chk("tr.data", 64'(lif.line_data[31:0]), 64'h44434241);
    ack();
    chk("tr.disc", 64'(lif.line_busy), 64'h1);
    chk("tr.trclr", 64'(lif.line_trunc), 64'h0);
    d0 = done_cnt;
    send(8'h45); send(8'h46); send(8'h0A);
    chk("tr.drop", 64'(lif.drop_flag), 64'h0);
    chk("tr.idle", 64'(lif.line_busy), 64'h0);
    send(8'h5A); send(8'h0A);
    chk("tr.done2", 64'(lif.line_done), 64'h1);
    chk("tr.len2", 64'(lif.line_length), 64'h1);
    chk("tr.data2", 64'(lif.line_data[7:0]), 64'h5A);
    chk("tr.trunc2", 64'(lif.line_trunc), 64'h0);
    chk("tr.ndone", 64'(done_cnt - d0), 64'h0);
    ack();

    // truncation, tail arrives while still held
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    send(8'h35); send(8'h0A);
    chk("trh.drop", 64'(lif.drop_flag), 64'h0);
    chk("trh.len", 64'(lif.line_length), 64'h4);
    ack();
    chk("trh.idle", 64'(lif.line_busy), 64'h0);

    // drop while held
    send(8'h4D); send(8'h4E); send(8'h0A);
    send(8'h51);
    chk("drp.flag", 64'(lif.drop_flag), 64'h1);
    chk("drp.len", 64'(lif.line_length), 64'h2);
    chk("drp.data", 64'(lif.line_data[15:0]), 64'h4E4D);
    ack();
    chk("drp.clr", 64'(lif.drop_flag), 64'h0);

    // same-cycle ack and byte in HOLD
    send(8'h52); send(8'h0A);
    @(negedge clk);
    lif.line_ack = 1'b1;
    lif.rx_byte  = 8'h53;
    lif.rx_valid = 1'b1;
    @(negedge clk);
    lif.line_ack = 1'b0;
    lif.rx_valid = 1'b0;
    chk("ackv.drop", 64'(lif.drop_flag), 64'h0);
    chk("ackv.busy", 64'(lif.line_busy), 64'h0);

    // rx_err aborts
    d0 = done_cnt;
    send(8'h41); send(8'h42);
    @(negedge clk);
    lif.rx_err = 1'b1;
    @(negedge clk);
    lif.rx_err = 1'b0;
    chk("err.busy", 64'(lif.line_busy), 64'h0);
    send(8'h43); send(8'h0A);
    @(negedge clk);
    chk("err.ndone", 64'(done_cnt - d0), 64'h1);
    chk("err.len", 64'(lif.line_length), 64'h1);
    chk("err.data", 64'(lif.line_data[7:0]), 64'h43);
    ack();

    // reset mid-line
    d0 = done_cnt;
    send(8'h41); send(8'h42);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mrst");
    repeat (20) @(negedge clk);
    chk("mrst.ndone", 64'(done_cnt - d0), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
